operand_entry_ctrl: RTL and testbench
=====================================

# operand_entry_ctrl

Front-end controller for the single-digit adder/subtractor. It synchronises and debounces the three push-keys, runs the field-select state machine (operand A, operator, operand B), and holds the edited operands with mod-10 digit arithmetic. It generates the field-blink enable for the 7-segment driver, then issues a request/acknowledge handshake to the arithmetic/display datapath. It replaces the per-key edge-clocked logic with a single `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles before a key level change is accepted (10 ms at 50 MHz); minimum 1.
- `BLINK_HALF`, 25000000: cycles per blink half-period; minimum 1.
- `clk` in 1: sole clock; all state is updated on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `right_toggle` in 1: raw key, active-low, asynchronous; advances the field.
- `up_toggle` in 1: raw key, active-low, asynchronous; increments the field.
- `down_toggle` in 1: raw key, active-low, asynchronous; decrements the field.
- `calc_ack` in 1: datapath acknowledge, sampled only while `calc_req`=1.
- `operand_a` out 4: first operand, 0..9.
- `operand_b` out 4: second operand, 0..9.
- `op_sub` out 1: 0 = add, 1 = subtract.
- `field_sel` out 2: 0 = none, 1 = A, 2 = operator, 3 = B.
- `blink` out 1: 1 = selected field visible.
- `calc_req` out 1: level request; the operands are valid and frozen while it is high.

## Operation
- **Key path**, per key:
  - 2-FF synchroniser, reset to 1.
  - Debounce counter: clears whenever the synced level equals the accepted level. Otherwise it increments. When it reaches `DEBOUNCE_CYCLES`, the accepted level takes the synced level and the counter clears.
  - Accepted level resets to 1.
  - A press produces a 1-cycle pulse (`pr_right`/`pr_up`/`pr_down`) on an accepted 1→0 transition. Release produces no event.
- **FSM states:**
  - IDLE (`field_sel`=0)
  - EDIT_A (1)
  - EDIT_OP (2)
  - EDIT_B (3)
  - REQ (`field_sel`=0, `calc_req`=1)
- **FSM transitions:**
  - `pr_right`: IDLE→EDIT_A→EDIT_OP→EDIT_B→REQ.
  - `pr_right` in REQ is ignored.
  - REQ with `calc_ack`=1 → IDLE on the next edge.
- **Edits**, applied only in EDIT_* states:
  - EDIT_A / EDIT_B with `pr_up`: value+1, 9 wraps to 0.
  - EDIT_A / EDIT_B with `pr_down`: value−1, 0 wraps to 9.
  - EDIT_OP with `pr_up` or `pr_down`: toggles `op_sub`.
  - `pr_up` and `pr_down` in the same cycle: no change.
  - `pr_right` together with `pr_up`/`pr_down` in the same cycle: the edit applies to the current field first, then the state advances.
- **IDLE and REQ:** `pr_up`/`pr_down` are ignored. Operands and `op_sub` hold their values across all transitions; only reset clears them.
- **Blink:**
  - Counter runs 0..2·`BLINK_HALF`−1 and wraps.
  - `blink` = (counter < `BLINK_HALF`) in EDIT_* states; constant 1 in IDLE and REQ.
  - The counter clears on every state change, so a newly selected field starts visible.
- **Handshake:**
  - `calc_req` rises on the edge entering REQ and stays high until `calc_ack` is sampled high.
  - `calc_ack` outside REQ is ignored.
  - The datapath reads operands only while `calc_req`=1.

## Timing
- **Reset values** (asynchronous, applied immediately):
  - `operand_a`=0, `operand_b`=0, `op_sub`=0, `field_sel`=0, `blink`=1, `calc_req`=0.
  - State IDLE; sync and accepted levels 1; all counters 0.
- **Key latency:** a clean key fall at cycle t gives a press pulse at t+2+`DEBOUNCE_CYCLES` (±1 for input sampling phase).
- **Glitch rejection:** glitches shorter than `DEBOUNCE_CYCLES` cycles produce no event.
- **Edit/state latency:** a press pulse at edge n gives the updated `field_sel`/operand/`op_sub` after edge n, visible in cycle n+1.
- **Handshake latency:** `calc_ack` sampled high at edge m gives `calc_req`=0 and `field_sel`=0 after edge m. The minimum REQ residency is 1 cycle.
- **Reset mid-REQ:** `calc_req` drops asynchronously. Any pending key events are discarded.
- **Blink period:** exactly 2·`BLINK_HALF` cycles, with a 50% duty cycle.

## Test plan
Parameters for the bench: `DEBOUNCE_CYCLES`=4, `BLINK_HALF`=8.
1. **Reset state:** assert `rst` mid-cycle → all outputs at their reset values with no clock edge. Hold `up_toggle` low in IDLE → `operand_a` stays 0.
2. **Debounce:** 3-cycle low glitch on `right_toggle` → `field_sel` stays 0. Clean press → `field_sel`=1 at 2+4 (+1) cycles after the key falls, one step only for a held key.
3. **Wrap-around:** EDIT_A, 10 `up` presses from 0 → `operand_a` back to 0. EDIT_B, one `down` from 0 → `operand_b`=9. EDIT_OP, `up` then `down` → `op_sub` 1 then 0.
4. **Simultaneous presses:** `up` and `down` debounced to the same cycle in EDIT_A with A=5 → `operand_a` stays 5.
5. **Full sequence:** A=7, `op_sub`=1, B=3, then `right` → `calc_req`=1 with operands stable. `up`/`right` presses during REQ are ignored. `calc_ack` high at edge m → `calc_req`=0 after edge m, `field_sel`=0, and A=7/B=3 are retained.
6. **Blink timing:** enter EDIT_B → `blink`=1 for 8 cycles, then 0 for 8 cycles, repeating. Press `right` mid-low-phase → `blink`=1 (REQ). Assert `rst` while `calc_req`=1 → `calc_req`=0 immediately and a later `calc_ack` is ignored.

Source files
------------

// File: rtl/operand_entry_ctrl.sv
// operand_entry_ctrl: key conditioning, field-select FSM, operand editing,
// field blink and request/acknowledge hand-off to the arithmetic datapath.
module operand_entry_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_HALF      = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       right_toggle,
   input  logic       up_toggle,
   input  logic       down_toggle,
   input  logic       calc_ack,
   output logic [3:0] operand_a,
   output logic [3:0] operand_b,
   output logic       op_sub,
   output logic [1:0] field_sel,
   output logic       blink,
   output logic       calc_req
);

   // Debounce counter only needs to reach DEBOUNCE_CYCLES-1 before accepting.
   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam int BL_W = (BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(2 * BLINK_HALF - 1);
   localparam logic [BL_W-1:0] BL_HALF = BL_W'(BLINK_HALF);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EDIT_A,
      S_EDIT_OP,
      S_EDIT_B,
      S_REQ
   } state_t;

   // Key bit order: 0 = right, 1 = up, 2 = down.
   logic [2:0]      key_raw;
   logic [2:0]      sync1_q, sync2_q;
   logic [2:0]      acc_q, acc_d;
   logic [2:0]      pr_q, pr_d;
   logic [DB_W-1:0] db_cnt_q [3];
   logic [DB_W-1:0] db_cnt_d [3];

   state_t          state_q, state_d;
   logic [3:0]      a_q, a_d;
   logic [3:0]      b_q, b_d;
   logic            op_q, op_d;
   logic            req_q, req_d;
   logic [1:0]      fsel_q, fsel_d;
   logic [BL_W-1:0] bl_cnt_q, bl_cnt_d;
   logic            blink_q, blink_d;

   logic            pr_right, pr_up, pr_dn;
   logic            inc_evt, dec_evt;

   function automatic logic [3:0] digit_inc(input logic [3:0] v);
      return (v >= 4'd9) ? 4'd0 : v + 4'd1;
   endfunction

   function automatic logic [3:0] digit_dec(input logic [3:0] v);
      return (v == 4'd0) ? 4'd9 : v - 4'd1;
   endfunction

   assign key_raw = {down_toggle, up_toggle, right_toggle};

   // Two-stage synchroniser for the asynchronous, active-low keys.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
      end
   end

   // Debounce: a level change is accepted after DEBOUNCE_CYCLES stable cycles;
   // an accepted fall is a press.
   always_comb begin
      acc_d = acc_q;
      pr_d  = 3'b000;
      for (int k = 0; k < 3; k++) begin
         db_cnt_d[k] = '0;
         if (sync2_q[k] != acc_q[k]) begin
            if (db_cnt_q[k] == DB_LAST) begin
               acc_d[k] = sync2_q[k];
               pr_d[k]  = ~sync2_q[k];
            end else begin
               db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
            end
         end
      end
   end

   // Debounce state and one-cycle press pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= 3'b111;
         pr_q  <= 3'b000;
         for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
      end else begin
         acc_q <= acc_d;
         pr_q  <= pr_d;
         for (int k = 0; k < 3; k++) db_cnt_q[k] <= db_cnt_d[k];
      end
   end

   assign pr_right = pr_q[0];
   assign pr_up    = pr_q[1];
   assign pr_dn    = pr_q[2];
   // Opposing presses in the same cycle cancel.
   assign inc_evt  = pr_up & ~pr_dn;
   assign dec_evt  = pr_dn & ~pr_up;

   // Field FSM, operand edits (applied before any advance), blink and request.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      req_d   = req_q;
      case (state_q)
         S_IDLE: begin
            if (pr_right) state_d = S_EDIT_A;
         end
         S_EDIT_A: begin
            if (inc_evt)      a_d = digit_inc(a_q);
            else if (dec_evt) a_d = digit_dec(a_q);
            if (pr_right) state_d = S_EDIT_OP;
         end
         S_EDIT_OP: begin
            if (inc_evt || dec_evt) op_d = ~op_q;
            if (pr_right) state_d = S_EDIT_B;
         end
         S_EDIT_B: begin
            if (inc_evt)      b_d = digit_inc(b_q);
            else if (dec_evt) b_d = digit_dec(b_q);
            if (pr_right) begin
               state_d = S_REQ;
               req_d   = 1'b1;
            end
         end
         S_REQ: begin
            if (calc_ack) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase

      case (state_d)
         S_EDIT_A:  fsel_d = 2'd1;
         S_EDIT_OP: fsel_d = 2'd2;
         S_EDIT_B:  fsel_d = 2'd3;
         default:   fsel_d = 2'd0;
      endcase

      // A new field restarts the blink cycle in its visible half.
      if (state_d != state_q)      bl_cnt_d = '0;
      else if (bl_cnt_q == BL_LAST) bl_cnt_d = '0;
      else                          bl_cnt_d = bl_cnt_q + BL_W'(1);

      if (state_d == S_EDIT_A || state_d == S_EDIT_OP || state_d == S_EDIT_B)
         blink_d = (bl_cnt_d < BL_HALF);
      else
         blink_d = 1'b1;
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= 4'd0;
         b_q      <= 4'd0;
         op_q     <= 1'b0;
         req_q    <= 1'b0;
         fsel_q   <= 2'd0;
         bl_cnt_q <= '0;
         blink_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         req_q    <= req_d;
         fsel_q   <= fsel_d;
         bl_cnt_q <= bl_cnt_d;
         blink_q  <= blink_d;
      end
   end

   assign operand_a = a_q;
   assign operand_b = b_q;
   assign op_sub    = op_q;
   assign field_sel = fsel_q;
   assign blink     = blink_q;
   assign calc_req  = req_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Testbench for operand_entry_ctrl with short debounce and blink periods.
module tb_operand_entry_ctrl;

   localparam int DB = 4;
   localparam int BH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       right_toggle = 1'b1;
   logic       up_toggle = 1'b1;
   logic       down_toggle = 1'b1;
   logic       calc_ack = 1'b0;
   logic [3:0] operand_a, operand_b;
   logic       op_sub;
   logic [1:0] field_sel;
   logic       blink;
   logic       calc_req;

   operand_entry_ctrl #(.DEBOUNCE_CYCLES(DB), .BLINK_HALF(BH)) dut (
      .clk(clk), .rst(rst),
      .right_toggle(right_toggle), .up_toggle(up_toggle), .down_toggle(down_toggle),
      .calc_ack(calc_ack),
      .operand_a(operand_a), .operand_b(operand_b), .op_sub(op_sub),
      .field_sel(field_sel), .blink(blink), .calc_req(calc_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       r, u, d;
      logic [3:0] a, b;
      logic       op;
      logic [1:0] fs;
      logic       req;
   } vec_t;

   typedef struct {
      logic [3:0] a, b;
      logic       op;
      logic [1:0] fs;
      logic       req;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic r, input logic u, input logic d,
                               input logic [3:0] a, input logic [3:0] b,
                               input logic op, input logic [1:0] fs, input logic req);
      vec_t v;
      v.r = r; v.u = u; v.d = d; v.a = a; v.b = b; v.op = op; v.fs = fs; v.req = req;
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Clean press of the selected keys, held long enough to be accepted, then released.
   task automatic press(input logic r, input logic u, input logic d);
      right_toggle = ~r;
      up_toggle    = ~u;
      down_toggle  = ~d;
      tick(DB + 4);
      right_toggle = 1'b1;
      up_toggle    = 1'b1;
      down_toggle  = 1'b1;
      tick(DB + 4);
   endtask

   initial begin
      int   n;
      exp_t e;
      bit   ok;

      // Edit table: EDIT_A ten ups from 0 (wraps back to 0).
      for (int i = 1; i <= 10; i++) vecs.push_back(mk(0, 1, 0, 4'(i % 10), 4'd0, 0, 2'd1, 0));
      // Down from 0 wraps to 9, then down to 5.
      for (int i = 9; i >= 5; i--) vecs.push_back(mk(0, 0, 1, 4'(i), 4'd0, 0, 2'd1, 0));
      // Up and down together: no change.
      vecs.push_back(mk(0, 1, 1, 4'd5, 4'd0, 0, 2'd1, 0));
      vecs.push_back(mk(0, 1, 0, 4'd6, 4'd0, 0, 2'd1, 0));
      vecs.push_back(mk(0, 1, 0, 4'd7, 4'd0, 0, 2'd1, 0));
      // Operator field toggles.
      vecs.push_back(mk(1, 0, 0, 4'd7, 4'd0, 0, 2'd2, 0));
      vecs.push_back(mk(0, 1, 0, 4'd7, 4'd0, 1, 2'd2, 0));
      vecs.push_back(mk(0, 0, 1, 4'd7, 4'd0, 0, 2'd2, 0));
      vecs.push_back(mk(0, 1, 0, 4'd7, 4'd0, 1, 2'd2, 0));
      // EDIT_B: down from 0 wraps to 9, then ups to 3.
      vecs.push_back(mk(1, 0, 0, 4'd7, 4'd0, 1, 2'd3, 0));
      vecs.push_back(mk(0, 0, 1, 4'd7, 4'd9, 1, 2'd3, 0));
      for (int i = 0; i <= 3; i++) vecs.push_back(mk(0, 1, 0, 4'd7, 4'(i), 1, 2'd3, 0));
      // Into REQ; further presses ignored.
      vecs.push_back(mk(1, 0, 0, 4'd7, 4'd3, 1, 2'd0, 1));
      vecs.push_back(mk(0, 1, 0, 4'd7, 4'd3, 1, 2'd0, 1));
      vecs.push_back(mk(1, 0, 0, 4'd7, 4'd3, 1, 2'd0, 1));
      vecs.push_back(mk(0, 0, 1, 4'd7, 4'd3, 1, 2'd0, 1));

      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("rst_a", operand_a, 0);
      chk("rst_b", operand_b, 0);
      chk("rst_op", op_sub, 0);
      chk("rst_fs", field_sel, 0);
      chk("rst_blink", blink, 1);
      chk("rst_req", calc_req, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Up held in IDLE is ignored.
      up_toggle = 1'b0;
      tick(12);
      up_toggle = 1'b1;
      tick(8);
      chk("idle_up_a", operand_a, 0);
      chk("idle_up_fs", field_sel, 0);

      // Short glitch on right is rejected.
      right_toggle = 1'b0;
      tick(DB - 1);
      right_toggle = 1'b1;
      tick(10);
      chk("glitch_fs", field_sel, 0);

      // Clean press latency and single step for a held key.
      right_toggle = 1'b0;
      n = 0;
      while (field_sel != 2'd1 && n < 20) begin
         tick(1);
         n++;
      end
      ok = (n == DB + 2) || (n == DB + 3);
      chk("press_latency_ok", int'(ok), 1);
      tick(12);
      chk("held_fs", field_sel, 1);
      right_toggle = 1'b1;
      tick(8);

      // Table-driven edits with a scoreboard of expected states.
      for (int i = 0; i < vecs.size(); i++) begin
         e.a = vecs[i].a; e.b = vecs[i].b; e.op = vecs[i].op;
         e.fs = vecs[i].fs; e.req = vecs[i].req;
         sb_q.push_back(e);
         press(vecs[i].r, vecs[i].u, vecs[i].d);
         e = sb_q.pop_front();
         chk($sformatf("v%0d_a", i), operand_a, e.a);
         chk($sformatf("v%0d_b", i), operand_b, e.b);
         chk($sformatf("v%0d_op", i), op_sub, e.op);
         chk($sformatf("v%0d_fs", i), field_sel, e.fs);
         chk($sformatf("v%0d_req", i), calc_req, e.req);
      end
      chk("req_blink", blink, 1);

      // Acknowledge ends the request after the sampling edge.
      calc_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("ack_req", calc_req, 0);
      chk("ack_fs", field_sel, 0);
      tick(1);
      calc_ack = 1'b0;
      chk("ack_a", operand_a, 7);
      chk("ack_b", operand_b, 3);
      chk("ack_op", op_sub, 1);

      // Second pass: walk to EDIT_B and watch the blink phase.
      press(1, 0, 0);
      chk("p2_fsA", field_sel, 1);
      press(1, 0, 0);
      chk("p2_fsOP", field_sel, 2);
      right_toggle = 1'b0;
      n = 0;
      while (field_sel != 2'd3 && n < 20) begin
         tick(1);
         n++;
      end
      chk("p2_fsB", field_sel, 3);
      for (int i = 0; i < 32; i++) begin
         if (i > 0) tick(1);
         if (i == 10) right_toggle = 1'b1;
         chk($sformatf("blink_%0d", i), blink, ((i % 16) < BH) ? 1 : 0);
      end
      tick(13);
      chk("blink_low", blink, 0);

      // Right pressed in the low phase enters REQ, blink forced on.
      right_toggle = 1'b0;
      n = 0;
      while (calc_req != 1'b1 && n < 20) begin
         tick(1);
         n++;
      end
      chk("p2_req", calc_req, 1);
      chk("p2_req_blink", blink, 1);
      chk("p2_req_fs", field_sel, 0);
      right_toggle = 1'b1;
      tick(3);

      // Reset mid-cycle while requesting.
      #2 rst = 1'b1;
      #1;
      chk("rst2_req", calc_req, 0);
      chk("rst2_a", operand_a, 0);
      chk("rst2_b", operand_b, 0);
      chk("rst2_op", op_sub, 0);
      chk("rst2_blink", blink, 1);
      tick(2);
      rst = 1'b0;
      calc_ack = 1'b1;
      tick(3);
      chk("late_ack_req", calc_req, 0);
      chk("late_ack_fs", field_sel, 0);
      calc_ack = 1'b0;
      tick(8);
      press(1, 0, 0);
      chk("after_rst_fs", field_sel, 1);
      chk("after_rst_a", operand_a, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule
